// File: rtl/bram_tdp_be.sv
// bram_tdp_be: true dual-port block RAM with byte-lane write enables.
//
// Two independent ports (A and B) share one clock. Each port performs at most
// one access per cycle (read, write, or both with write taking priority) and
// returns its read word a fixed latency later, qualified by rvalid.
//
// Parameters
//   AWIDTH   address width (depth = 2**AWIDTH words)
//   DWIDTH   data word width (multiple of BYTE_W)
//   BYTE_W   byte-lane width; NBE = DWIDTH/BYTE_W lanes
//   RDW_MODE same-port read-during-write: 0 write-first, 1 read-first,
//            2 no-change (rq held, no rvalid for the write)
//   OREG     1 adds an output register stage (latency 2 instead of 1)
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   rce_x, wce_x          read / write enable for port x (A or B)
//   addr_x, be_x, wd_x    address, byte enables, write data
//   rq_x, rvalid_x        read data and its one-cycle qualifier
//   coll, coll_cnt        write-write collision pulse and saturating count
//
// Optional feature: define BRAM_TDP_BE_COLL_DETECT_EN to build the collision
// detector. Without it coll and coll_cnt are tied to zero; write arbitration
// (port A wins overlapping lanes) is the same in both builds.
module bram_tdp_be #(
  parameter int AWIDTH   = 10,
  parameter int DWIDTH   = 36,
  parameter int BYTE_W   = 9,
  parameter int RDW_MODE = 0,
  parameter int OREG     = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rce_a,
  input  logic                       wce_a,
  input  logic [AWIDTH-1:0]          addr_a,
  input  logic [DWIDTH/BYTE_W-1:0]   be_a,
  input  logic [DWIDTH-1:0]          wd_a,
  output logic [DWIDTH-1:0]          rq_a,
  output logic                       rvalid_a,
  input  logic                       rce_b,
  input  logic                       wce_b,
  input  logic [AWIDTH-1:0]          addr_b,
  input  logic [DWIDTH/BYTE_W-1:0]   be_b,
  input  logic [DWIDTH-1:0]          wd_b,
  output logic [DWIDTH-1:0]          rq_b,
  output logic                       rvalid_b,
  output logic                       coll,
  output logic [15:0]                coll_cnt
);

  localparam int NBE   = DWIDTH / BYTE_W;
  localparam int DEPTH = 2 ** AWIDTH;

  // Replace the enabled lanes of old_w with the matching lanes of new_w.
  function automatic logic [DWIDTH-1:0] merge_bytes(
    input logic [DWIDTH-1:0] old_w,
    input logic [DWIDTH-1:0] new_w,
    input logic [NBE-1:0]    be
  );
    logic [DWIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NBE; i++) begin
      if (be[i]) res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction

  // Array powers up cleared; reset never touches it.
  logic [DWIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [DWIDTH-1:0] old_a, old_b;
  logic [DWIDTH-1:0] rd_data_a, rd_data_b;
  logic              rd_vld_a, rd_vld_b;

  logic [DWIDTH-1:0] rq_a_p0, rq_b_p0;
  logic              vld_a_p0, vld_b_p0;

  // Both ports see the pre-edge contents, so a cross-port read of a word being
  // written returns the old word.
  always_comb begin
    old_a     = mem[addr_a];
    old_b     = mem[addr_b];
    // Write has priority over read; no-change mode suppresses the response.
    rd_vld_a  = wce_a ? (RDW_MODE != 2) : rce_a;
    rd_vld_b  = wce_b ? (RDW_MODE != 2) : rce_b;
    rd_data_a = (wce_a && RDW_MODE == 0) ? merge_bytes(old_a, wd_a, be_a) : old_a;
    rd_data_b = (wce_b && RDW_MODE == 0) ? merge_bytes(old_b, wd_b, be_b) : old_b;
  end

  // Port B lanes are written first so that port A's later assignment wins in
  // lanes both ports enable on the same address.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NBE; i++) begin
        if (wce_b && be_b[i]) mem[addr_b][i*BYTE_W +: BYTE_W] <= wd_b[i*BYTE_W +: BYTE_W];
      end
      for (int i = 0; i < NBE; i++) begin
        if (wce_a && be_a[i]) mem[addr_a][i*BYTE_W +: BYTE_W] <= wd_a[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // ---- stage p0: array read register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_a_p0 <= 1'b0;
      vld_b_p0 <= 1'b0;
      rq_a_p0  <= '0;
      rq_b_p0  <= '0;
    end else begin
      vld_a_p0 <= rd_vld_a;
      vld_b_p0 <= rd_vld_b;
      if (rd_vld_a) rq_a_p0 <= rd_data_a;
      if (rd_vld_b) rq_b_p0 <= rd_data_b;
    end
  end

  generate
    if (OREG == 1) begin : g_oreg
      logic [DWIDTH-1:0] rq_a_p1, rq_b_p1;
      logic              vld_a_p1, vld_b_p1;

      // ---- stage p1: optional output register ----
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_a_p1 <= 1'b0;
          vld_b_p1 <= 1'b0;
          rq_a_p1  <= '0;
          rq_b_p1  <= '0;
        end else begin
          vld_a_p1 <= vld_a_p0;
          vld_b_p1 <= vld_b_p0;
          rq_a_p1  <= rq_a_p0;
          rq_b_p1  <= rq_b_p0;
        end
      end

      assign rq_a     = rq_a_p1;
      assign rq_b     = rq_b_p1;
      assign rvalid_a = vld_a_p1;
      assign rvalid_b = vld_b_p1;
    end else begin : g_noreg
      assign rq_a     = rq_a_p0;
      assign rq_b     = rq_b_p0;
      assign rvalid_a = vld_a_p0;
      assign rvalid_b = vld_b_p0;
    end
  endgenerate

`ifdef BRAM_TDP_BE_COLL_DETECT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        coll_hit;
  logic        coll_p0;
  logic [15:0] coll_cnt_p0;

  // Only a double write with at least one shared lane loses data.
  assign coll_hit = wce_a & wce_b & (addr_a == addr_b) & (|(be_a & be_b));

  // ---- stage p0: collision flag and counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_p0     <= 1'b0;
      coll_cnt_p0 <= '0;
    end else begin
      coll_p0 <= coll_hit;
      if (coll_hit) coll_cnt_p0 <= sat_inc(coll_cnt_p0);
    end
  end

  assign coll     = coll_p0;
  assign coll_cnt = coll_cnt_p0;
`else
  assign coll     = 1'b0;
  assign coll_cnt = '0;
`endif

endmodule

// File: doc/bram_tdp_be.md
BRAM_TDP_BE -- requirements
Module: bram_tdp_be

Interface
REQ-001 SHALL have parameter AWIDTH, default 10, address width; depth is 2**AWIDTH words.
REQ-002 SHALL have parameter DWIDTH, default 36, data word width.
REQ-003 SHALL have parameter BYTE_W, default 9, byte-lane width; DWIDTH shall be a multiple of BYTE_W, and NBE = DWIDTH/BYTE_W.
REQ-004 SHALL have parameter RDW_MODE, default 0, same-port read-during-write behaviour: 0 write-first, 1 read-first, 2 no-change.
REQ-005 SHALL have parameter OREG, default 0, adding one output register stage when set to 1.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have ports rce_a / rce_b, input, 1 each, read enable for port A / B.
REQ-010 SHALL have ports wce_a / wce_b, input, 1 each, write enable for port A / B.
REQ-011 SHALL have ports addr_a / addr_b, input, AWIDTH each, shared read/write address for port A / B.
REQ-012 SHALL have ports be_a / be_b, input, NBE each, byte enables; bit i covers data bits [i*BYTE_W +: BYTE_W].
REQ-013 SHALL have ports wd_a / wd_b, input, DWIDTH each, write data.
REQ-014 SHALL have ports rq_a / rq_b, output, DWIDTH each, read data.
REQ-015 SHALL have ports rvalid_a / rvalid_b, output, 1 each, rq qualifier, one cycle per access.
REQ-016 SHALL have port coll, output, 1, write-write collision pulse.
REQ-017 SHALL have port coll_cnt, output, 16, collision count.

Function
REQ-018 SHALL start array contents at all-zero at time 0; rst_n never alters the array.
REQ-019 SHALL, on wce_x, write only the enabled byte lanes of wd_x to addr_x; wce_x with be_x = 0 writes nothing but still counts as an access.
REQ-020 SHALL give wce_x priority over rce_x; an access is rce_x | wce_x.
REQ-021 SHALL produce rq/rvalid 1 cycle after an access when OREG=0 and 2 cycles after when OREG=1; fully pipelined, one access per port per cycle.
REQ-022 SHALL, on a same-port write with RDW_MODE=0, return the merged post-write word (new enabled bytes, old other bytes).
REQ-023 SHALL, on a same-port write with RDW_MODE=1, return the pre-write word.
REQ-024 SHALL, on a same-port write with RDW_MODE=2, hold rq unchanged and keep rvalid low for that access.
REQ-025 SHALL, on a cross-port read and write to the same address in the same cycle, return the pre-write word to the reading port.
REQ-026 SHALL, when both ports write the same address in the same cycle, write port A's bytes in overlapping enabled lanes and each port's own bytes in non-overlapping lanes.
REQ-027 SHALL hold rq between accesses; rvalid is low in cycles with no response.

Reset
REQ-028 SHALL, while rst_n=0, force rq_a, rq_b, rvalid_a, rvalid_b, coll and coll_cnt to 0 asynchronously and clear all pipeline stages.
REQ-029 SHALL discard accesses in flight when reset asserts mid-operation; no rvalid for them after release.
REQ-030 SHALL accept accesses on the first rising clk edge after rst_n deasserts.

Configuration
REQ-031 SHALL compile collision detection in when macro BRAM_TDP_BE_COLL_DETECT_EN is defined: coll pulses 1 cycle after a same-address double write with overlapping byte enables, and coll_cnt increments then, saturating at 16'hFFFF.
REQ-032 SHALL tie coll and coll_cnt to 0 when BRAM_TDP_BE_COLL_DETECT_EN is undefined; write arbitration per REQ-026 is unchanged.

Verification
REQ-033 SHALL cover: OREG=0, A writes 36'h123456789 at 5 with be=4'hF, then A reads 5 -> rq_a=36'h123456789 with rvalid_a 1 cycle after the read.
REQ-034 SHALL cover: word 7 = 36'h0, A writes 36'hFFFFFFFFF with be=4'b0010, then B reads 7 -> rq_b=36'h00003FE00.
REQ-035 SHALL cover: RDW_MODE=0/1/2, word 3 = 36'hA, A writes 36'hB at 3 -> rq_a=36'hB / 36'hA / unchanged with rvalid_a=0.
REQ-036 SHALL cover: macro defined, A and B both write 9 with be=4'hF, wd_a=1, wd_b=2 -> word 9 = 1, coll pulses, coll_cnt=1.
REQ-037 SHALL cover: OREG=1, read issued, then rst_n pulsed low in the next cycle -> rvalid_a stays 0 and rq_a=0 after release.
